// File: rtl/fifo_uart_tx_if.sv
// Byte hand-off from the FIFO into the UART drain stage, plus the serial-side status.
// master = FIFO/system side, slave = fifo_uart_tx.
interface fifo_uart_tx_if;
  logic        nostock;
  logic [7:0]  fifo_dout;
  logic        rd;
  logic        txd;
  logic        busy;
  logic        tx_done;
  logic [15:0] frame_count;

  modport master (output nostock, fifo_dout, input rd, txd, busy, tx_done, frame_count);
  modport slave  (input nostock, fifo_dout, output rd, txd, busy, tx_done, frame_count);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain + async serialiser: pulls one byte per frame and sends start, 8 data (LSB first),
// optional even parity (build with PARITY_EN defined), and STOP_BITS stop bits.
// state | meaning:  IDLE wait for data | REQ rd strobe | LOAD capture byte | START start bit
//                   DATA data bits     | PAR parity bit | STOP stop bit(s), tx_done on last cycle
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PAR, STOP} state_t;

  localparam logic [15:0] BAUD_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic        STOP_LAST_IDX = 1'(STOP_BITS - 1);

  state_t      state, state_nxt;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic [7:0]  shift;
  logic [15:0] frame_count;
  logic        bit_end, stop_last;
  logic        txd_c, rd_c, busy_c, tx_done_c;
`ifdef PARITY_EN
  logic        par_bit;
`endif

  assign bit_end   = (baud == BAUD_LAST);
  assign stop_last = bit_end && (stop_idx == STOP_LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!bus.nostock) state_nxt = REQ;
      REQ:   state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
`ifdef PARITY_EN
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = PAR;
      PAR:   if (bit_end) state_nxt = STOP;
`else
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:  if (stop_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    txd_c     = 1'b1;
    rd_c      = 1'b0;
    busy_c    = 1'b1;
    tx_done_c = 1'b0;
    case (state)
      IDLE:  busy_c = 1'b0;
      REQ:   rd_c = 1'b1;
      START: txd_c = 1'b0;
      DATA:  txd_c = shift[0];
`ifdef PARITY_EN
      PAR:   txd_c = par_bit;
`endif
      STOP:  tx_done_c = stop_last;
      default: ;
    endcase
  end

  // Baud counter only runs inside the serial part of the frame, so it starts at 0 on START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud        <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shift       <= '0;
      frame_count <= '0;
`ifdef PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      if (state == IDLE || state == REQ || state == LOAD || bit_end) baud <= '0;
      else                                                          baud <= baud + 16'd1;

      if (state == LOAD) begin
        shift    <= bus.fifo_dout;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
`ifdef PARITY_EN
        par_bit  <= ^bus.fifo_dout;
`endif
      end

      if (state == DATA && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == STOP && bit_end && !stop_last) stop_idx <= stop_idx + 1'b1;
      if (state == STOP && stop_last)             frame_count <= frame_count + 16'd1;
    end
  end

  assign bus.txd         = txd_c;
  assign bus.rd          = rd_c;
  assign bus.busy        = busy_c;
  assign bus.tx_done     = tx_done_c;
  assign bus.frame_count = frame_count;

endmodule
